// File: rtl/div_pkg.sv
// Shared types and constants for the iterative radix-2 divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_STEPS = 32;
    localparam int unsigned CNT_W     = $clog2(DIV_STEPS);

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [DIV_WIDTH-1:0] DIV_OVF_S  = 32'h8000_0000;
    localparam logic [DIV_WIDTH-1:0] DIV_OVF_T  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } div_state_e;

    function automatic logic [DIV_WIDTH-1:0] negate(input logic [DIV_WIDTH-1:0] x);
        return DIV_WIDTH'(~x + DIV_WIDTH'(1));
    endfunction

    // Two's-complement magnitude when signed, raw operand otherwise.
    function automatic logic [DIV_WIDTH-1:0] magnitude(input logic [DIV_WIDTH-1:0] x,
                                                       input logic              sgn);
        return (sgn && x[DIV_WIDTH-1]) ? negate(x) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep the difference if it did not borrow.
module div_step
    import div_pkg::*;
(
    input  logic [DIV_WIDTH:0]   rem_i,
    input  logic [DIV_WIDTH-1:0] dmag_i,
    input  logic                 bit_i,
    output logic [DIV_WIDTH:0]   rem_c_o,
    output logic                 qbit_c_o
);

    logic [DIV_WIDTH+1:0] shifted;
    logic [DIV_WIDTH+1:0] diff;

    always_comb begin
        shifted  = {rem_i, bit_i};
        diff     = shifted - {2'b00, dmag_i};
        qbit_c_o = ~diff[DIV_WIDTH+1];
        rem_c_o  = qbit_c_o ? diff[DIV_WIDTH:0] : shifted[DIV_WIDTH:0];
    end

endmodule

// File: rtl/iter_div.sv
// Iterative 32-bit signed/unsigned divider, one quotient bit per cycle.
// ITER_DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow finish in one cycle.
module iter_div
    import div_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 is_signed,
    input  logic [DIV_WIDTH-1:0] s,
    input  logic [DIV_WIDTH-1:0] t,
    output logic                 completed,
    output logic [DIV_WIDTH-1:0] q,
    output logic [DIV_WIDTH-1:0] r
);

    div_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DIV_WIDTH:0]   rem_q, rem_d;
    logic [DIV_WIDTH-1:0] dvd_q, dvd_d;
    logic [DIV_WIDTH-1:0] dmag_q, dmag_d;
    logic [DIV_WIDTH-1:0] s_q, s_d;
    logic                 t31_q, t31_d;
    logic                 sgn_q, sgn_d;
    logic [DIV_WIDTH-1:0] q_q, q_d;
    logic [DIV_WIDTH-1:0] r_q, r_d;
    logic                 completed_q, completed_d;

    logic [DIV_WIDTH:0]   step_rem;
    logic                 step_qbit;

    // dvd_q shifts left each step: dividend bits leave the top, quotient bits enter the bottom.
    div_step u_step (
        .rem_i    (rem_q),
        .dmag_i   (dmag_q),
        .bit_i    (dvd_q[DIV_WIDTH-1]),
        .rem_c_o  (step_rem),
        .qbit_c_o (step_qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dmag_q      <= '0;
            s_q         <= '0;
            t31_q       <= 1'b0;
            sgn_q       <= 1'b0;
            q_q         <= '0;
            r_q         <= '0;
            completed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dmag_q      <= dmag_d;
            s_q         <= s_d;
            t31_q       <= t31_d;
            sgn_q       <= sgn_d;
            q_q         <= q_d;
            r_q         <= r_d;
            completed_q <= completed_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dmag_d      = dmag_q;
        s_d         = s_q;
        t31_d       = t31_q;
        sgn_d       = sgn_q;
        q_d         = q_q;
        r_d         = r_q;
        completed_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    s_d    = s;
                    t31_d  = t[DIV_WIDTH-1];
                    sgn_d  = is_signed;
                    dvd_d  = magnitude(s, is_signed);
                    dmag_d = magnitude(t, is_signed);
                    rem_d  = '0;
                    cnt_d  = '0;
`ifdef ITER_DIV_FAST_SPECIAL_EN
                    if (t == '0) begin
                        q_d         = DIV_ZERO_Q;
                        r_d         = s;
                        completed_d = 1'b1;
                    end else if (is_signed && (s == DIV_OVF_S) && (t == DIV_OVF_T)) begin
                        q_d         = DIV_OVF_S;
                        r_d         = '0;
                        completed_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
`else
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[DIV_WIDTH-2:0], step_qbit};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
                    state_d = FIX;
                    cnt_d   = '0;
                end
            end
            FIX: begin
                // First FIX cycle loads the result; second holds FIX while completed is high.
                if (!completed_q) begin
                    completed_d = 1'b1;
                    if (dmag_q == '0) begin
                        q_d = DIV_ZERO_Q;
                        r_d = s_q;
                    end else begin
                        q_d = (sgn_q && (s_q[DIV_WIDTH-1] ^ t31_q)) ? negate(dvd_q) : dvd_q;
                        r_d = (sgn_q && s_q[DIV_WIDTH-1]) ? negate(rem_q[DIV_WIDTH-1:0])
                                                          : rem_q[DIV_WIDTH-1:0];
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign completed = completed_q;
    assign q         = q_q;
    assign r         = r_q;

endmodule

// File: tb/tb_iter_div.sv
// Directed self-checking bench for iter_div: vector table plus busy/reset sequences.
module tb_iter_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        is_signed;
    logic [31:0] s;
    logic [31:0] t;
    logic        completed;
    logic [31:0] q;
    logic [31:0] r;

    always #5 clk = ~clk;

    iter_div dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .is_signed (is_signed),
        .s         (s),
        .t         (t),
        .completed (completed),
        .q         (q),
        .r         (r)
    );

    localparam int NORM_LAT = 34;
`ifdef ITER_DIV_FAST_SPECIAL_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 34;
`endif

    typedef struct {
        logic [31:0] s;
        logic [31:0] t;
        logic        sg;
        logic [31:0] eq;
        logic [31:0] er;
        bit          special;
    } vec_t;

    vec_t vecs[12];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pulse enable for one cycle, then scramble the operand inputs.
    task automatic start(input logic [31:0] sv, input logic [31:0] tv, input logic sg);
        @(negedge clk);
        enable    = 1'b1;
        s         = sv;
        t         = tv;
        is_signed = sg;
        @(negedge clk);
        enable    = 1'b0;
        s         = $urandom;
        t         = $urandom;
        is_signed = 1'($urandom);
    endtask

    // Counts cycles after the start cycle until completed; -1 on timeout.
    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int n = 1; n <= budget; n++) begin
            if (completed) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        int pulses;
        int first_lat;
        logic [31:0] got_q;
        logic [31:0] got_r;

        vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
        vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
        vecs[2]  = '{32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1};
        vecs[3]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b1};
        vecs[4]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0};
        vecs[5]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0};
        vecs[6]  = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF,  1'b0};
        vecs[7]  = '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1};
        vecs[8]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[9]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0,          1'b0};
        vecs[10] = '{32'd3,          32'd10,         1'b0, 32'd0,          32'd3,          1'b0};
        vecs[11] = '{32'h1234_5678,  32'h0000_1000,  1'b0, 32'h0001_2345,  32'h0000_0678,  1'b0};

        rst       = 1'b1;
        enable    = 1'b0;
        is_signed = 1'b0;
        s         = '0;
        t         = '0;
        repeat (3) @(negedge clk);
        check("reset_completed", 32'(completed), 32'd0);
        check("reset_q", q, 32'd0);
        check("reset_r", r, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            start(vecs[i].s, vecs[i].t, vecs[i].sg);
            wait_done(60, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat),
                  32'(vecs[i].special ? SPEC_LAT : NORM_LAT));
            check($sformatf("vec%0d_q", i), q, vecs[i].eq);
            check($sformatf("vec%0d_r", i), r, vecs[i].er);
            @(negedge clk);
            check($sformatf("vec%0d_pulse_width", i), 32'(completed), 32'd0);
        end

        // Second enable mid-RUN must be ignored.
        start(32'd100, 32'd7, 1'b0);
        pulses    = 0;
        first_lat = -1;
        got_q     = '0;
        got_r     = '0;
        for (int n = 1; n <= 80; n++) begin
            enable = (n == 10);
            if (n == 10) begin
                s         = 32'd9;
                t         = 32'd3;
                is_signed = 1'b0;
            end
            if (completed) begin
                pulses++;
                if (first_lat < 0) begin
                    first_lat = n;
                    got_q     = q;
                    got_r     = r;
                end
            end
            @(negedge clk);
        end
        enable = 1'b0;
        check("busy_latency", 32'(first_lat), 32'(NORM_LAT));
        check("busy_q", got_q, 32'd14);
        check("busy_r", got_r, 32'd2);
        check("busy_pulses", 32'(pulses), 32'd1);

        // Enable coinciding with the completed pulse must be ignored.
        start(32'd20, 32'd6, 1'b0);
        wait_done(60, lat);
        check("cc_latency", 32'(lat), 32'(NORM_LAT));
        check("cc_q", q, 32'd3);
        check("cc_r", r, 32'd2);
        enable = 1'b1;
        s      = 32'd9;
        t      = 32'd3;
        @(negedge clk);
        enable = 1'b0;
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            if (completed) pulses++;
            @(negedge clk);
        end
        check("cc_no_restart", 32'(pulses), 32'd0);
        check("cc_hold_q", q, 32'd3);
        check("cc_hold_r", r, 32'd2);

        // Reset at cycle 20 of an operation, then restart immediately.
        start(32'd1000, 32'd10, 1'b0);
        pulses = 0;
        for (int n = 1; n < 20; n++) begin
            if (completed) pulses++;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_no_pulse_before", 32'(pulses), 32'd0);
        check("rst_completed", 32'(completed), 32'd0);
        check("rst_q", q, 32'd0);
        check("rst_r", r, 32'd0);
        enable    = 1'b1;
        s         = 32'd9;
        t         = 32'd3;
        is_signed = 1'b0;
        @(negedge clk);
        enable = 1'b0;
        s      = $urandom;
        t      = $urandom;
        wait_done(60, lat);
        check("post_rst_latency", 32'(lat), 32'(NORM_LAT));
        check("post_rst_q", q, 32'd3);
        check("post_rst_r", r, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iter_div.md
ITER_DIV -- requirements
Module: iter_div

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; no parameters.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 enable  input  1  one-cycle start pulse from the issuing unit.
REQ-005 is_signed  input  1  1 = two's-complement divide (div/rem), 0 = unsigned (divu/remu).
REQ-006 s  input  32  dividend.
REQ-007 t  input  32  divisor.
REQ-008 completed  output  1  one-cycle pulse; q and r are valid in that cycle.
REQ-009 q  output  32  quotient, registered.
REQ-010 r  output  32  remainder, registered.

Function
REQ-011 States: IDLE, RUN, FIX. Reset state is IDLE.
REQ-012 Start condition: IDLE and enable=1. The block SHALL latch s, t and is_signed at that edge. Only the latched copies are used afterwards.
REQ-013 Iteration scheme: radix-2 restoring on magnitudes, one quotient bit per cycle, MSB first.
- Magnitudes: |s| and |t| when is_signed=1; raw values otherwise.
- Partial remainder: 33 bits.
REQ-014 IDLE to RUN on start; step counter loaded with 0.
- RUN lasts exactly 32 cycles. After the step with counter=31 the block SHALL go to FIX.
REQ-015 Sign correction in FIX, applied only when is_signed=1:
- q negated when s[31] differs from t[31].
- r negated when s[31]=1.
- Then load q and r, pulse completed for one cycle, return to IDLE.
REQ-016 Normal latency: completed SHALL be high in the 34th cycle after the cycle in which enable was sampled high.
REQ-017 Divide by zero (t=0) SHALL give q=32'hFFFFFFFF and r=s, for both signednesses.
REQ-018 Signed overflow (s=32'h80000000, t=32'hFFFFFFFF, is_signed=1) SHALL give q=32'h80000000 and r=0.
REQ-019 enable SHALL be ignored while in RUN or FIX. Inputs that change during RUN or FIX SHALL have no effect.
REQ-020 enable in the same cycle as a completed pulse SHALL be ignored, because the state is FIX, not IDLE. A new start is accepted from the following cycle.
REQ-021 completed SHALL be 0 in every cycle except the one result cycle of each operation.
REQ-022 q and r SHALL hold their last values until the next result cycle.

Reset
REQ-023 rst=1 SHALL, at the next edge and from any state including mid-RUN:
- force IDLE, completed=0, q=0, r=0, step counter=0;
- discard any in-flight operation, with no completed pulse for it.
REQ-024 After rst is released, the block SHALL accept enable in the first cycle.

Configuration
REQ-025 Macro ITER_DIV_FAST_SPECIAL_EN.
- When defined: t=0, or the signed-overflow case, SHALL bypass RUN and FIX. The result is loaded and completed pulses in the cycle after enable is sampled (latency 1).
- When undefined: these cases SHALL take the normal 34-cycle path, with results per REQ-017 and REQ-018.
- The t=0 result SHALL be forced in FIX rather than taken from the iteration.
- Results SHALL be bit-identical in both builds; only latency differs.

Structure
REQ-026 Package div_pkg SHALL hold:
- the state enum (IDLE, RUN, FIX);
- DIV_WIDTH=32 and DIV_STEPS=32;
- the DIV_ZERO_Q constant 32'hFFFFFFFF.
REQ-027 Sub-module div_step SHALL implement one combinational restoring iteration.
- Inputs: partial remainder, divisor magnitude, next dividend bit.
- Outputs: new partial remainder and quotient bit.
- iter_div instantiates it once.

Verification
REQ-028 Unsigned: s=100, t=7, is_signed=0 -> completed exactly 34 cycles later with q=14, r=2.
REQ-029 Signed: s=32'hFFFFFFF9 (-7), t=2, is_signed=1 -> q=32'hFFFFFFFD (-3), r=32'hFFFFFFFF (-1).
REQ-030 Divide by zero: s=32'hFFFFFFF9, t=0, is_signed=1 -> q=32'hFFFFFFFF, r=32'hFFFFFFF9. Latency is 1 with the macro, 34 without.
REQ-031 Overflow: s=32'h80000000, t=32'hFFFFFFFF, is_signed=1 -> q=32'h80000000, r=0. The same operands with is_signed=0 -> q=0, r=32'h80000000.
REQ-032 Busy and reset:
- A second enable at cycle 10 with s=9, t=3 SHALL be ignored; only the first result appears.
- rst at cycle 20 of an operation -> no completed pulse, q=r=0.
- The next start after reset SHALL complete normally.
